// File: rtl/acq_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// acq_sequencer_pkg
//
// Purpose : Shared definitions for the acquisition sequencer slice: the FSM
//           state encoding, the latency counter width and a saturating
//           increment helper used by the latency counter.
//
// Contents:
//   acq_state_e    2-bit FSM state (IDLE=0, ARM=1, ALIGN=2, WRITE=3)
//   LATENCY_WIDTH  width of the start-to-first-write latency counter
//   sat_inc()      increment that sticks at all ones instead of wrapping
// -----------------------------------------------------------------------------
package acq_sequencer_pkg;

  // Encoding is fixed so status readers and debug probes can decode it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ALIGN = 2'd2,
    WRITE = 2'd3
  } acq_state_e;

  localparam int unsigned LATENCY_WIDTH = 32;

  // Saturating increment: a stuck-at-max value is more useful to software
  // than one that silently wraps back to a small number.
  function automatic logic [LATENCY_WIDTH-1:0] sat_inc(
    input logic [LATENCY_WIDTH-1:0] value
  );
    if (&value) begin
      return value;
    end
    return value + LATENCY_WIDTH'(1);
  endfunction

endpackage : acq_sequencer_pkg

// File: rtl/acq_latency_counter.sv
// -----------------------------------------------------------------------------
// acq_latency_counter
//
// Purpose : Saturating 32-bit cycle counter measuring how long a sequence
//           waits between start acceptance and its first BRAM write. Once
//           frozen it keeps its value until the next clear, so later shots of
//           the same sequence do not disturb the measurement.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset (count=0, not frozen)
//   clear   in   zero the count and release the freeze (new sequence)
//   enable  in   count this cycle (ignored while frozen)
//   freeze  in   stop counting until the next clear
//   count   out  current latency value
// -----------------------------------------------------------------------------
module acq_latency_counter
  import acq_sequencer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     enable,
  input  logic                     freeze,
  output logic [LATENCY_WIDTH-1:0] count
);

  logic frozen;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      frozen <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      frozen <= 1'b0;
    end else begin
      if (freeze) begin
        frozen <= 1'b1;
      end
      // A freeze arriving in the same cycle as enable wins, so the value
      // never moves once the first write has been reached.
      if (enable && !frozen && !freeze) begin
        count <= sat_inc(count);
      end
    end
  end

endmodule : acq_latency_counter

// File: rtl/acq_sequencer.sv
// -----------------------------------------------------------------------------
// acq_sequencer
//
// Purpose : Sequences BRAM capture shots. After a start request it optionally
//           waits for an external trigger edge, then aligns to the datapath's
//           free-running write address wrapping to zero, and asserts the BRAM
//           write enable for exactly one full BRAM (2^BRAM_WIDTH cycles). This
//           repeats for n_shots shots, then pulses done. abort returns to
//           IDLE at any time without a done pulse.
//
// Parameters:
//   BRAM_WIDTH  BRAM address width; one shot is 2^BRAM_WIDTH samples
//   SHOT_WIDTH  width of the shot-count configuration and status
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle sequence request, honoured only in IDLE
//   abort       in   level; ends any sequence, highest priority
//   trig_en     in   per-shot trigger gating, sampled with start
//   trig        in   external trigger, rising edge used
//   n_shots     in   shots per sequence (0 means 1), sampled with start
//   address     in   free-running BRAM write address from the datapath
//   wen         out  registered BRAM write enable
//   busy        out  high whenever the FSM is not in IDLE
//   done        out  one-cycle pulse after the final write of a sequence
//   shot_count  out  shots completed in the current or last sequence
//   latency     out  cycles from start acceptance to the first write
// -----------------------------------------------------------------------------
module acq_sequencer
  import acq_sequencer_pkg::*;
#(
  parameter int BRAM_WIDTH = 13,
  parameter int SHOT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     trig_en,
  input  logic                     trig,
  input  logic [SHOT_WIDTH-1:0]    n_shots,
  input  logic [BRAM_WIDTH-1:0]    address,
  output logic                     wen,
  output logic                     busy,
  output logic                     done,
  output logic [SHOT_WIDTH-1:0]    shot_count,
  output logic [LATENCY_WIDTH-1:0] latency
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  acq_state_e            state;
  acq_state_e            next_state;

  logic                  trig_q;       // previous-cycle trig for edge detect
  logic                  trig_rise;
  logic [BRAM_WIDTH-1:0] wr_cnt;       // position inside the current shot
  logic [SHOT_WIDTH-1:0] n_shots_q;    // latched target, never zero
  logic                  trig_en_q;
  logic [SHOT_WIDTH-1:0] shot_next;

  logic                  last_write;   // final cycle of the current shot
  logic                  final_shot;   // current shot completes the sequence

  // Output-decode strobes
  logic                  start_accept;
  logic                  shot_inc;
  logic                  wen_d;
  logic                  done_d;
  logic                  lat_clear;
  logic                  lat_enable;
  logic                  lat_freeze;

  // ---------------------------------------------------------------------------
  // Inline helpers: trigger edge detector and shot bookkeeping
  // ---------------------------------------------------------------------------
  assign trig_rise  = trig & ~trig_q;
  assign last_write = (state == WRITE) && (&wr_cnt);

  // shot_count < n_shots_q <= all ones whenever a shot completes, so the
  // increment cannot wrap and a plain SHOT_WIDTH-bit compare is exact.
  assign shot_next  = shot_count + SHOT_WIDTH'(1);
  assign final_shot = (shot_next == n_shots_q);

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic. abort is checked first so it overrides
  // start, trigger edges and shot completion alike.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            next_state = trig_en ? ARM : ALIGN;
          end
        end
        ARM: begin
          if (trig_rise) begin
            next_state = ALIGN;
          end
        end
        ALIGN: begin
          if (address == '0) begin
            next_state = WRITE;
          end
        end
        WRITE: begin
          if (&wr_cnt) begin
            if (final_shot) begin
              next_state = IDLE;
            end else begin
              next_state = trig_en_q ? ARM : ALIGN;
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output decode. wen is registered from next_state, so it is
  // high exactly in the cycles the FSM sits in WRITE and drops the cycle after
  // an abort or reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    start_accept = (state == IDLE) && start && !abort;
    shot_inc     = last_write && !abort;
    wen_d        = (next_state == WRITE);
    done_d       = last_write && final_shot && !abort;
    lat_clear    = start_accept;
    // Counting only happens while waiting (ARM/ALIGN); the first WRITE cycle
    // freezes the value for the rest of the sequence.
    lat_enable   = ((state == ARM) || (state == ALIGN)) && !abort;
    lat_freeze   = (state == WRITE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q     <= 1'b0;
      wr_cnt     <= '0;
      n_shots_q  <= '0;
      trig_en_q  <= 1'b0;
      shot_count <= '0;
      wen        <= 1'b0;
      done       <= 1'b0;
    end else begin
      trig_q <= trig;
      wen    <= wen_d;
      done   <= done_d;

      // Counter runs only inside WRITE and is zero on every entry to it.
      if (state == WRITE) begin
        wr_cnt <= wr_cnt + BRAM_WIDTH'(1);
      end else begin
        wr_cnt <= '0;
      end

      if (start_accept) begin
        n_shots_q  <= (n_shots == '0) ? SHOT_WIDTH'(1) : n_shots;
        trig_en_q  <= trig_en;
        shot_count <= '0;
      end else if (shot_inc) begin
        shot_count <= shot_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Start-to-first-write latency
  // ---------------------------------------------------------------------------
  acq_latency_counter u_latency (
    .clk    (clk),
    .rst    (rst),
    .clear  (lat_clear),
    .enable (lat_enable),
    .freeze (lat_freeze),
    .count  (latency)
  );

endmodule : acq_sequencer

// File: tb/tb_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acq_sequencer
//
// Self-checking bench for acq_sequencer with a 16-sample BRAM and 4-bit shot
// count. A behavioural model tracks the sequence as "phase + writes left in
// this shot + shots done" and one compare process checks every DUT output
// against it on every cycle. Directed scenarios pin the model with literal
// expectations, then randomized traffic exercises trig/abort/start/rst mixes.
// -----------------------------------------------------------------------------
module tb_acq_sequencer;

  localparam int BW       = 4;
  localparam int SW       = 4;
  localparam int SHOT_LEN = 1 << BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          trig_en;
  logic          trig;
  logic [SW-1:0] n_shots;
  logic [BW-1:0] address;
  logic          wen;
  logic          busy;
  logic          done;
  logic [SW-1:0] shot_count;
  logic [31:0]   latency;

  int total = 0;
  int bad   = 0;

  // Observed DUT activity, written only by the compare process.
  int wen_cycles  = 0;
  int done_pulses = 0;

  acq_sequencer #(
    .BRAM_WIDTH (BW),
    .SHOT_WIDTH (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .trig_en    (trig_en),
    .trig       (trig),
    .n_shots    (n_shots),
    .address    (address),
    .wen        (wen),
    .busy       (busy),
    .done       (done),
    .shot_count (shot_count),
    .latency    (latency)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   phase: 0 idle, 1 waiting for trigger edge, 2 waiting for address 0,
  //          3 writing (writes_left counts down the shot)
  // ---------------------------------------------------------------------------
  int          m_phase       = 0;
  int          m_writes_left = 0;
  int          m_shots       = 0;
  int          m_target      = 1;
  bit          m_te          = 0;
  bit          m_prev_trig   = 0;
  bit          m_waiting_lat = 0;
  bit          m_done        = 0;
  logic [31:0] m_lat         = '0;

  always @(posedge clk) begin
    bit rise;
    rise        = trig && !m_prev_trig;
    m_prev_trig = trig;
    m_done      = 0;
    if (rst) begin
      m_phase       = 0;
      m_writes_left = 0;
      m_shots       = 0;
      m_lat         = '0;
      m_waiting_lat = 0;
      m_prev_trig   = 0;
    end else if (abort) begin
      m_phase = 0;
    end else begin
      if ((m_phase == 1 || m_phase == 2) && m_waiting_lat && m_lat != 32'hFFFF_FFFF)
        m_lat = m_lat + 32'd1;
      case (m_phase)
        0: if (start) begin
          m_target      = (n_shots == 0) ? 1 : int'(n_shots);
          m_te          = trig_en;
          m_shots       = 0;
          m_lat         = '0;
          m_waiting_lat = 1;
          m_phase       = trig_en ? 1 : 2;
        end
        1: if (rise) m_phase = 2;
        2: if (address == 0) begin
          m_phase       = 3;
          m_writes_left = SHOT_LEN;
          m_waiting_lat = 0;
        end
        default: begin
          m_writes_left--;
          if (m_writes_left == 0) begin
            m_shots++;
            if (m_shots == m_target) begin
              m_phase = 0;
              m_done  = 1;
            end else begin
              m_phase = m_te ? 1 : 2;
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Single compare process: every cycle, #1 after the rising edge.
  // ---------------------------------------------------------------------------
  initial begin
    @(posedge clk);
    forever begin
      @(posedge clk);
      #1;
      check("wen",        64'(wen),        64'(m_phase == 3));
      check("busy",       64'(busy),       64'(m_phase != 0));
      check("done",       64'(done),       64'(m_done));
      check("shot_count", 64'(shot_count), 64'(m_shots));
      check("latency",    64'(latency),    64'(m_lat));
      if (wen)  wen_cycles++;
      if (done) done_pulses++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    address = address + BW'(1);
  endtask

  task automatic pulse_start(input int ns, input bit te);
    n_shots = SW'(ns);
    trig_en = te;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy; i++) step();
    check({name, "_reaches_idle"}, 64'(busy), 64'd0);
    step();
  endtask

  task automatic wait_wen(input string name, input int base, input int target, input int budget);
    for (int i = 0; i < budget && (wen_cycles - base) < target; i++) step();
    check({name, "_wen_reached"}, 64'(wen_cycles - base), 64'(target));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int w0;
    int d0;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    trig_en = 1'b0;
    trig    = 1'b0;
    n_shots = '0;
    address = '0;
    repeat (3) step();

    // Reset state
    check("rst_wen",        64'(wen),        64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_shot_count", 64'(shot_count), 64'd0);
    check("rst_latency",    64'(latency),    64'd0);
    rst = 1'b0;
    step();

    // Single untriggered shot, start while address == 5
    for (int i = 0; i < 20 && address != BW'(5); i++) step();
    check("a_addr_is_5", 64'(address), 64'd5);
    w0 = wen_cycles; d0 = done_pulses;
    pulse_start(1, 1'b0);
    wait_idle("a", 100);
    check("a_latency",    64'(latency),            64'd11);
    check("a_shot_count", 64'(shot_count),         64'd1);
    check("a_wen_cycles", 64'(wen_cycles - w0),    64'd16);
    check("a_done",       64'(done_pulses - d0),   64'd1);

    // Three triggered shots, trigger pulses 100 cycles apart
    w0 = wen_cycles; d0 = done_pulses;
    pulse_start(3, 1'b1);
    for (int c = 1; c <= 320; c++) begin
      trig = (c % 100 == 50);
      step();
    end
    trig = 1'b0;
    wait_idle("b", 100);
    check("b_shot_count", 64'(shot_count),       64'd3);
    check("b_wen_cycles", 64'(wen_cycles - w0),  64'd48);
    check("b_done",       64'(done_pulses - d0), 64'd1);

    // Abort on the 8th write cycle of shot 2
    w0 = wen_cycles; d0 = done_pulses;
    pulse_start(3, 1'b0);
    wait_wen("c", w0, 24, 200);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("c_wen_after_abort",  64'(wen),               64'd0);
    check("c_busy_after_abort", 64'(busy),              64'd0);
    repeat (20) step();
    check("c_shot_count",       64'(shot_count),        64'd1);
    check("c_wen_cycles",       64'(wen_cycles - w0),   64'd24);
    check("c_no_done",          64'(done_pulses - d0),  64'd0);

    // trig high before arming must not fire; start during WRITE ignored
    trig = 1'b1;
    repeat (3) step();
    w0 = wen_cycles; d0 = done_pulses;
    pulse_start(1, 1'b1);
    repeat (40) step();
    check("d_no_write_on_held_trig", 64'(wen_cycles - w0), 64'd0);
    check("d_still_armed",           64'(busy),            64'd1);
    trig = 1'b0;
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    wait_wen("d", w0, 5, 100);
    n_shots = SW'(5);
    trig_en = 1'b0;
    start   = 1'b1;
    trig    = 1'b1;
    step();
    start   = 1'b0;
    trig    = 1'b0;
    wait_idle("d", 100);
    check("d_shot_count", 64'(shot_count),       64'd1);
    check("d_wen_cycles", 64'(wen_cycles - w0),  64'd16);
    check("d_done",       64'(done_pulses - d0), 64'd1);

    // Reset mid-WRITE, then n_shots = 0 runs exactly one shot
    w0 = wen_cycles;
    pulse_start(2, 1'b0);
    wait_wen("e", w0, 6, 100);
    rst = 1'b1;
    step();
    step();
    check("e_rst_wen",        64'(wen),        64'd0);
    check("e_rst_busy",       64'(busy),       64'd0);
    check("e_rst_done",       64'(done),       64'd0);
    check("e_rst_shot_count", 64'(shot_count), 64'd0);
    check("e_rst_latency",    64'(latency),    64'd0);
    rst = 1'b0;
    step();
    w0 = wen_cycles; d0 = done_pulses;
    pulse_start(0, 1'b0);
    wait_idle("e", 100);
    check("e_shot_count", 64'(shot_count),       64'd1);
    check("e_wen_cycles", 64'(wen_cycles - w0),  64'd16);
    check("e_done",       64'(done_pulses - d0), 64'd1);

    // Start in the same cycle done pulses
    w0 = wen_cycles; d0 = done_pulses;
    pulse_start(1, 1'b0);
    wait_wen("f", w0, 16, 100);
    step();
    check("f_done_now", 64'(done), 64'd1);
    n_shots = SW'(2);
    trig_en = 1'b0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    check("f_busy_restart",  64'(busy),       64'd1);
    check("f_shot_cleared",  64'(shot_count), 64'd0);
    wait_idle("f", 200);
    check("f_shot_count", 64'(shot_count),       64'd2);
    check("f_done",       64'(done_pulses - d0), 64'd2);

    // Maximum shot count completes without wrapping
    d0 = done_pulses;
    pulse_start(15, 1'b0);
    wait_idle("g", 800);
    check("g_shot_count", 64'(shot_count),       64'd15);
    check("g_done",       64'(done_pulses - d0), 64'd1);

    // Randomized traffic against the model
    for (int it = 0; it < 20; it++) begin
      pulse_start(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 250; c++) begin
        trig    = ($urandom_range(0, 19) == 0);
        abort   = ($urandom_range(0, 199) == 0);
        rst     = ($urandom_range(0, 799) == 0);
        start   = ($urandom_range(0, 59) == 0);
        n_shots = SW'($urandom_range(0, 3));
        trig_en = 1'($urandom_range(0, 1));
        step();
      end
      trig  = 1'b0;
      start = 1'b0;
      rst   = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_acq_sequencer

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter BRAM_WIDTH, default 13, BRAM address width; one shot is 2^BRAM_WIDTH samples.
REQ-002 Parameter SHOT_WIDTH, default 16, width of the shot-count configuration and status.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin a sequence.
REQ-006 abort  in  1  level; terminates any sequence.
REQ-007 trig_en  in  1  selects whether each shot waits for an external trigger; sampled when start is accepted.
REQ-008 trig  in  1  external trigger, synchronous to clk; the rising edge is used.
REQ-009 n_shots  in  SHOT_WIDTH  shots per sequence; sampled when start is accepted.
REQ-010 address  in  BRAM_WIDTH  free-running BRAM write address from the datapath.
REQ-011 wen  out  1  BRAM write enable, registered.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse when the sequence completes normally.
REQ-014 shot_count  out  SHOT_WIDTH  shots completed in the current or last sequence.
REQ-015 latency  out  32  cycles from start acceptance to the first wen of the sequence.

Function
REQ-016 FSM states SHALL be IDLE, ARM, ALIGN, WRITE.
REQ-017 IDLE: start=1 and abort=0 -> latch n_shots (0 treated as 1) and trig_en; clear shot_count and latency; next state ARM if trig_en=1, else ALIGN.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 ARM: a trig rising edge (trig=1 now, trig=0 previous cycle) -> ALIGN; trig held high on entry does not fire.
REQ-020 ALIGN: address==0 sampled -> WRITE on the next cycle, with the write counter cleared.
REQ-021 WRITE: wen=1 for exactly 2^BRAM_WIDTH consecutive cycles; the BRAM_WIDTH-bit counter increments each cycle.
REQ-022 Last WRITE cycle (counter all ones): shot_count increments. If shot_count+1 equals the latched n_shots, next state is IDLE and done pulses one cycle later. Otherwise, next state is ARM (trig_en=1) or ALIGN (trig_en=0).
REQ-023 wen SHALL be 0 in IDLE, ARM and ALIGN; there are no gaps inside a shot.
REQ-024 latency counts every cycle from the cycle after start acceptance up to the cycle before the first wen=1, then freezes.
REQ-025 latency SHALL saturate at 0xFFFFFFFF.
REQ-026 abort=1 in any state -> IDLE next cycle, wen=0 next cycle, no done pulse; shot_count and latency hold.
REQ-027 abort SHALL have priority over start, trig and all counter transitions.
REQ-028 shot_count SHALL not wrap: n_shots=2^SHOT_WIDTH-1 completes with shot_count=all ones.
REQ-029 Simultaneous events:
- done and a new start in the same cycle: start is accepted (state is already IDLE).
- A trig edge in ALIGN or WRITE: ignored.

Reset
REQ-030 rst=1 -> state IDLE; wen, busy, done=0; shot_count=0; latency=0; trig edge register=0; write counter=0.
REQ-031 rst mid-WRITE SHALL deassert wen the next cycle and discard the shot.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2 bits: IDLE=0, ARM=1, ALIGN=2, WRITE=3).
REQ-033 One sub-module SHALL implement the saturating 32-bit latency counter: acq_latency_counter (clear, enable, freeze).
REQ-034 No other sub-modules; the rising-edge detector and write counter are inline.

Verification
REQ-035 BRAM_WIDTH=4, trig_en=0, n_shots=1, start while address=5 -> first wen the cycle after address==0; wen high exactly 16 cycles; done pulse; shot_count=1; latency=11.
REQ-036 trig_en=1, n_shots=3, trig pulses 100 cycles apart -> three 16-cycle wen bursts, each after a trig edge and then address==0; done once; shot_count=3.
REQ-037 abort asserted on the 8th wen cycle of shot 2 -> wen=0 next cycle, no done, shot_count=1, busy=0.
REQ-038 start during WRITE; trig held high before arming -> both ignored; no extra shot; ARM waits for a fresh edge.
REQ-039 rst mid-WRITE, then start with n_shots=0 -> all outputs 0 after reset; the sequence runs exactly 1 shot.
REQ-040 start accepted in the same cycle done pulses -> the new sequence starts; shot_count clears to 0; busy stays high.
